// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Request/response bundle between the memory stage (master) and the data
//   memory responder (slave).
//
//   req_valid  : request present this cycle
//   req_ready  : responder can accept a request this cycle
//   req_write  : 1 = write, 0 = read
//   req_double : 1 = two-word access (addr, addr+1), 0 = single word
//   req_addr   : word address of the first (low) word
//   req_wdata  : write data, [W-1:0] -> addr, [2W-1:W] -> addr+1
//   rsp_valid  : one-cycle completion pulse
//   rsp_rdata  : read data, valid while rsp_valid=1 for a read
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_double;
  logic [AW-1:0]     req_addr;
  logic [2*W-1:0]    req_wdata;
  logic              rsp_valid;
  logic [2*W-1:0]    rsp_rdata;

  modport master (
    output req_valid, req_write, req_double, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_double, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Owns the 2^AW x W data memory and services single-word and double-word
//   (addr, addr+1) read/write requests from the memory stage. Single accesses
//   respond one cycle after accept; double accesses perform the second word
//   on the following edge and respond one cycle after that.
//
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset (memory contents are kept)
//   bus  : slave side of data_mem_responder_if (request/response handshake)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t          state;

  // Single-port synchronous array; not reset.
  logic [W-1:0]    mem [2**AW];

  // Second-word context captured at a double-access accept.
  logic [AW-1:0]   lat_addr;
  logic [W-1:0]    lat_wdata;
  logic            lat_write;

  logic            rsp_valid;
  logic [2*W-1:0]  rsp_rdata;

  logic            ready;
  logic            accept;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [W-1:0]    mem_wdata;

  // Ready also drops while reset is held so nothing is accepted then.
  always_comb begin
    ready  = (state == IDLE) && rst;
    accept = bus.req_valid && ready;
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;

  // Write port select: a new accept in IDLE, or the latched second word in
  // SECOND. Kept outside the reset block so the array carries no reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wdata = bus.req_wdata[W-1:0];
    if (state == SECOND) begin
      mem_we    = lat_write && rst;
      mem_waddr = lat_addr;
      mem_wdata = lat_wdata;
    end else begin
      mem_we    = accept && bus.req_write;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            if (bus.req_double) begin
              // Word0 now; word1 context is latched so later req_* changes
              // cannot affect it.
              lat_addr  <= bus.req_addr + AW'(1);
              lat_wdata <= bus.req_wdata[2*W-1:W];
              lat_write <= bus.req_write;
              if (!bus.req_write) begin
                rsp_rdata[W-1:0] <= mem[bus.req_addr];
              end
              state <= SECOND;
            end else begin
              if (!bus.req_write) begin
                rsp_rdata <= {{W{1'b0}}, mem[bus.req_addr]};
              end
              rsp_valid <= 1'b1;
            end
          end
        end

        SECOND: begin
          // Low half of rsp_rdata is left untouched here.
          if (!lat_write) begin
            rsp_rdata[2*W-1:W] <= mem[lat_addr];
          end
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder: a vector table applied
//   back-to-back, plus hand sequences for an ignored request during SECOND
//   and a reset in the middle of a double write. Expected responses are
//   queued when a request is driven and compared when rsp_valid appears.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  logic clk;
  logic rst;

  data_mem_responder_if #(.W(16), .AW(11)) bus ();

  data_mem_responder #(.W(16), .AW(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    bit          wr;
    bit          dbl;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // expected rsp_rdata for reads
  } vec_t;

  vec_t vecs[18];

  // rsp_rdata is expected to keep its last read value across writes.
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor, mid-cycle away from the active edge.
  always @(negedge clk) begin
    sb_t e;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("FAIL rsp_missing actual=none required=cycle%0d data=%h", e.cyc, e.data);
    end
    if (bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_spurious actual=rsp_valid=1 required=rsp_valid=0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        chk("rsp_rdata", bus.rsp_rdata, e.data);
      end
    end
  end

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom_range(0, 1));
    bus.req_double = 1'($urandom_range(0, 1));
    bus.req_addr   = 11'($urandom);
    bus.req_wdata  = $urandom;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge on which
  // the responder is idle again.
  task automatic issue(input bit wr, input bit dbl, input logic [10:0] a,
                       input logic [31:0] wd, input logic [31:0] exp);
    sb_t e;
    chk("ready_idle", 32'(bus.req_ready), 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_double = dbl;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    if (!wr) last_rd = exp;
    e.cyc  = cyc + (dbl ? 2 : 1);
    e.data = last_rd;
    sbq.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    if (dbl) begin
      chk("ready_second", 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 11'h010, 32'h0000_00A5, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 11'h010, 32'h0,         32'h0000_00A5};
    vecs[2]  = '{1'b1, 1'b1, 11'h7FF, 32'h1234_ABCD, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 11'h7FF, 32'h0,         32'h0000_ABCD};
    vecs[4]  = '{1'b0, 1'b0, 11'h000, 32'h0,         32'h0000_1234};
    vecs[5]  = '{1'b0, 1'b1, 11'h7FF, 32'h0,         32'h1234_ABCD};
    vecs[6]  = '{1'b1, 1'b0, 11'h100, 32'h0000_0001, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 11'h101, 32'h0000_0002, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 11'h102, 32'h0000_0003, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 11'h103, 32'h0000_0004, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 11'h100, 32'h0,         32'h0000_0001};
    vecs[11] = '{1'b0, 1'b0, 11'h101, 32'h0,         32'h0000_0002};
    vecs[12] = '{1'b0, 1'b0, 11'h102, 32'h0,         32'h0000_0003};
    vecs[13] = '{1'b0, 1'b0, 11'h103, 32'h0,         32'h0000_0004};
    vecs[14] = '{1'b1, 1'b1, 11'h040, 32'hBEEF_CAFE, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 11'h041, 32'h0,         32'h0000_BEEF};
    vecs[16] = '{1'b1, 1'b0, 11'h041, 32'hFFFF_0011, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 11'h040, 32'h0,         32'h0011_CAFE};

    // Reset state, checked while reset is held.
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("ready_after_reset", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;

    // Table, applied back-to-back.
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].wr, vecs[i].dbl, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end
    wait_cycles(3);

    // Request during SECOND must be ignored.
    issue(1'b1, 1'b0, 11'h020, 32'h0000_0123, 32'h0);
    begin
      sb_t e;
      chk("ready_idle", 32'(bus.req_ready), 32'h1);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_double = 1'b1;
      bus.req_addr   = 11'h050;
      bus.req_wdata  = 32'h0002_0001;
      e.cyc  = cyc + 2;
      e.data = last_rd;
      sbq.push_back(e);
      @(posedge clk); #1;
      chk("ready_second", 32'(bus.req_ready), 32'h0);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_double = 1'b0;
      bus.req_addr   = 11'h020;
      bus.req_wdata  = 32'h0000_FFFF;
      @(posedge clk); #1;
      idle_inputs();
    end
    issue(1'b0, 1'b0, 11'h020, 32'h0, 32'h0000_0123);
    issue(1'b0, 1'b0, 11'h051, 32'h0, 32'h0000_0002);
    issue(1'b0, 1'b0, 11'h050, 32'h0, 32'h0000_0001);
    wait_cycles(3);

    // Reset in the middle of a double write.
    issue(1'b1, 1'b0, 11'h031, 32'h0000_7777, 32'h0);
    issue(1'b0, 1'b0, 11'h031, 32'h0,         32'h0000_7777);
    chk("ready_idle", 32'(bus.req_ready), 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_double = 1'b1;
    bus.req_addr   = 11'h030;
    bus.req_wdata  = 32'h5555_AAAA;
    @(posedge clk); #1;
    idle_inputs();
    chk("ready_second", 32'(bus.req_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midreset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("midreset_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    last_rd = 32'h0;
    #1;
    chk("ready_after_midreset", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("post_reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    end
    issue(1'b0, 1'b0, 11'h030, 32'h0, 32'h0000_AAAA);
    issue(1'b0, 1'b0, 11'h031, 32'h0, 32'h0000_7777);

    wait_cycles(4);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
